// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central pipeline sequencer for the 5-stage 16-bit core. It produces the
//   PC write/select controls and the pipeline-register enables and flushes.
//   These are driven by EX-stage redirects, load-use hazards seen in ID,
//   data-memory busy and the HALT instruction. On HALT the front of the pipe
//   is squashed, the older instructions retire for DRAIN cycles, and the
//   block then parks until reset. A saturating stall counter is kept for
//   performance debug.
//
//   The control outputs are Mealy. They are combinational from the state and
//   the current inputs, so they act at the same rising edge.
//
// Parameters
//   WIDTH : PC / address width
//   REGW  : register specifier width
//   DRAIN : cycles after HALT leaves EX before halted asserts (DRAIN >= 1)
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   ex_valid, ex_pcsrc            EX holds a real instr / resolved taken redirect
//   ex_pc_next                    redirect target from EX
//   ex_halt                       EX instruction is HALT
//   id_ex_memread, id_ex_rd       EX instruction is a load / its destination
//   if_id_rs, if_id_rt            ID source specifiers
//   if_id_rs_used, if_id_rt_used  ID really reads rs / rt
//   mem_busy                      data memory not ready this cycle
//   pc_we, pc_sel, pc_target      PC write enable, redirect select, target
//   if_id_we, id_ex_we, ex_mem_we pipeline register enables
//   if_id_flush, id_ex_flush      load a bubble into the register
//   halted                        core stopped
//   stall_cnt                     saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_pcsrc,
  input  logic [WIDTH-1:0] ex_pc_next,
  input  logic             ex_halt,
  input  logic             id_ex_memread,
  input  logic [REGW-1:0]  id_ex_rd,
  input  logic [REGW-1:0]  if_id_rs,
  input  logic [REGW-1:0]  if_id_rt,
  input  logic             if_id_rs_used,
  input  logic             if_id_rt_used,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [WIDTH-1:0] pc_target,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  localparam int CNT_W = ($clog2(DRAIN + 1) > 0) ? $clog2(DRAIN + 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           eff_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ret_drain_r;
  logic             ret_drain_nxt_s;
  logic             stall_inc_s;
  logic [15:0]      stall_cnt_r;
  logic             load_use_s;

  // The ID instruction needs the result of a load that is still in EX.
  // r0 is deliberately not excluded.
  function automatic logic load_use_hazard(
    input logic            memread,
    input logic [REGW-1:0] rd,
    input logic [REGW-1:0] rs,
    input logic [REGW-1:0] rt,
    input logic            rs_used,
    input logic            rt_used
  );
    return memread & ((rs_used & (rs == rd)) | (rt_used & (rt == rd)));
  endfunction

  assign load_use_s = load_use_hazard(id_ex_memread, id_ex_rd, if_id_rs, if_id_rt,
                                      if_id_rs_used, if_id_rt_used);
  assign pc_target  = ex_pc_next;
  assign stall_cnt  = stall_cnt_r;

  // Effective state for this cycle. On the first non-busy cycle of MEM_WAIT
  // the block already behaves as the state it is returning to. Because EX was
  // frozen, a pending redirect or HALT is then re-evaluated.
  always_comb begin
    eff_s = state_r;
    if ((state_r == ST_MEM_WAIT) && !mem_busy) begin
      if (ret_drain_r) begin
        eff_s = ST_DRAIN;
      end else begin
        eff_s = ST_RUN;
      end
    end else begin
      eff_s = state_r;
    end
  end

  // Mealy control outputs and next-state decode.
  always_comb begin
    pc_we           = 1'b0;
    pc_sel          = 1'b0;
    if_id_we        = 1'b0;
    id_ex_we        = 1'b0;
    ex_mem_we       = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    halted          = 1'b0;
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    ret_drain_nxt_s = ret_drain_r;
    stall_inc_s     = 1'b0;

    case (eff_s)
      ST_RUN: begin
        if (mem_busy) begin
          // Freeze everything until memory answers.
          state_nxt_s     = ST_MEM_WAIT;
          ret_drain_nxt_s = 1'b0;
          stall_inc_s     = 1'b1;
        end else if (ex_valid && ex_halt) begin
          // Squash the younger instructions and let EX/MEM/WB retire.
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = DRAIN_LOAD;
        end else if (ex_valid && ex_pcsrc) begin
          // Redirect. A load-use dependent in ID is squashed anyway.
          pc_we       = 1'b1;
          pc_sel      = 1'b1;
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (load_use_s) begin
          // Hold PC and IF/ID, insert a bubble behind the advancing load.
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          id_ex_flush = 1'b1;
          stall_inc_s = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          state_nxt_s = ST_RUN;
        end
      end

      ST_MEM_WAIT: begin
        // Only reached here while mem_busy is still high.
        stall_inc_s = 1'b1;
        state_nxt_s = ST_MEM_WAIT;
      end

      ST_DRAIN: begin
        if (mem_busy) begin
          // Retiring instructions are stuck. Keep the counter and come back.
          state_nxt_s     = ST_MEM_WAIT;
          ret_drain_nxt_s = 1'b1;
        end else begin
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = ST_HALT;
          end else begin
            cnt_nxt_s   = cnt_r - CNT_ONE;
            state_nxt_s = ST_DRAIN;
          end
        end
      end

      ST_HALT: begin
        halted      = 1'b1;
        state_nxt_s = ST_HALT;
      end

      default: begin
        // Unreachable encoding: fall back to a safe running state.
        state_nxt_s     = ST_RUN;
        cnt_nxt_s       = CNT_ZERO;
        ret_drain_nxt_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, drain counter and return flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      cnt_r       <= CNT_ZERO;
      ret_drain_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ret_drain_r <= ret_drain_nxt_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. Each cycle an expected record
//   goes into a scoreboard queue when the stimulus is driven. The observed
//   outputs are captured at the falling edge. Each test task then pops both
//   queues and compares them. The control word is
//   {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, halted}.
//   A mask leaves out the bits whose value is not defined for that cycle.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int WIDTH = 16;
  localparam int REGW  = 3;
  localparam int DRAIN = 2;

  localparam logic [7:0] C_RUN    = 8'b1011_1000;
  localparam logic [7:0] C_BR     = 8'b1111_1110;
  localparam logic [7:0] C_LU     = 8'b0000_1010;
  localparam logic [7:0] C_DRN    = 8'b0000_1010;
  localparam logic [7:0] C_HIN    = 8'b0000_1110;
  localparam logic [7:0] C_STALL  = 8'b0000_0000;
  localparam logic [7:0] C_HALTED = 8'b0000_0001;
  localparam logic [7:0] M_ALL    = 8'b1111_1111;
  localparam logic [7:0] M_LU     = 8'b1110_1011;
  localparam logic [7:0] M_HIN    = 8'b1100_1111;
  localparam logic [7:0] M_EN     = 8'b1111_1001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_pcsrc, ex_halt;
  logic [WIDTH-1:0] ex_pc_next;
  logic             id_ex_memread;
  logic [REGW-1:0]  id_ex_rd, if_id_rs, if_id_rt;
  logic             if_id_rs_used, if_id_rt_used, mem_busy;
  logic             pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we;
  logic             if_id_flush, id_ex_flush, halted;
  logic [WIDTH-1:0] pc_target;
  logic [15:0]      stall_cnt;

  pipe_hazard_ctrl #(.WIDTH(WIDTH), .REGW(REGW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pcsrc(ex_pcsrc), .ex_pc_next(ex_pc_next), .ex_halt(ex_halt),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_rs_used(if_id_rs_used), .if_id_rt_used(if_id_rt_used),
    .mem_busy(mem_busy),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ex_valid, ex_pcsrc, ex_halt, memread, rs_used, rt_used, mem_busy;
    logic [2:0]  rd, rs, rt;
    logic [15:0] pc_next;
  } in_t;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [7:0]  msk;
    logic        chk_tgt;
    logic [15:0] tgt;
    logic        chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] tgt;
    logic [15:0] cnt;
  } obs_t;

  exp_t        sb[$];
  obs_t        obs_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_cnt = 16'h0000;

  function automatic in_t idle_in();
    in_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic in_t lu_in(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                                input logic rs_used, input logic rt_used);
    in_t i;
    i = idle_in();
    i.memread = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt;
    i.rs_used = rs_used; i.rt_used = rt_used;
    return i;
  endfunction

  // Drive one cycle. Push its expectation, capture outputs at negedge, leave at posedge+1.
  task automatic apply(input in_t i, input string nm, input logic [7:0] ctl, input logic [7:0] msk,
                       input logic chk_tgt, input logic [15:0] tgt, input logic chk_cnt,
                       input logic stall);
    exp_t e;
    obs_t o;
    ex_valid = i.ex_valid; ex_pcsrc = i.ex_pcsrc; ex_halt = i.ex_halt; ex_pc_next = i.pc_next;
    id_ex_memread = i.memread; id_ex_rd = i.rd; if_id_rs = i.rs; if_id_rt = i.rt;
    if_id_rs_used = i.rs_used; if_id_rt_used = i.rt_used; mem_busy = i.mem_busy;
    e.name = nm; e.ctl = ctl; e.msk = msk; e.chk_tgt = chk_tgt; e.tgt = tgt;
    e.chk_cnt = chk_cnt; e.cnt = model_cnt;
    sb.push_back(e);
    if (stall && (model_cnt != 16'hFFFF)) model_cnt = model_cnt + 16'd1;
    @(negedge clk);
    o.ctl = {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, halted};
    o.tgt = pc_target;
    o.cnt = stall_cnt;
    obs_q.push_back(o);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; obs_t o;
    rst_n = 1'b0;
    apply(idle_in(), "rst_low", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(idle_in(), "idle0", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(), "idle1", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e; obs_t o;
    apply(lu_in(3'd3, 3'd3, 3'd0, 1'b1, 1'b0), "lu_rs",     C_LU,  M_LU,  1'b0, 16'h0, 1'b1, 1'b1);
    apply(idle_in(),                          "lu_clear",  C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(lu_in(3'd3, 3'd3, 3'd0, 1'b0, 1'b0), "lu_unused", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(lu_in(3'd5, 3'd1, 3'd5, 1'b0, 1'b1), "lu_rt",     C_LU,  M_LU,  1'b0, 16'h0, 1'b1, 1'b1);
    apply(lu_in(3'd0, 3'd0, 3'd2, 1'b1, 1'b1), "lu_r0",     C_LU,  M_LU,  1'b0, 16'h0, 1'b1, 1'b1);
    apply(lu_in(3'd4, 3'd2, 3'd6, 1'b1, 1'b1), "lu_nomatch", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(),                          "lu_after",  C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; obs_t o; in_t i;
    i = lu_in(3'd3, 3'd3, 3'd0, 1'b1, 1'b0);
    i.ex_valid = 1'b1; i.ex_pcsrc = 1'b1; i.pc_next = 16'h0040;
    apply(i, "br_over_lu", C_BR, M_ALL, 1'b1, 16'h0040, 1'b1, 1'b0);
    i = idle_in(); i.ex_valid = 1'b1; i.ex_pcsrc = 1'b1; i.pc_next = 16'hBEEF;
    apply(i, "br_b2b", C_BR, M_ALL, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    i = lu_in(3'd2, 3'd2, 3'd0, 1'b1, 1'b0); i.ex_pcsrc = 1'b1; i.pc_next = 16'h1111;
    apply(i, "br_invalid", C_LU, M_LU, 1'b0, 16'h0, 1'b1, 1'b1);
    apply(idle_in(), "br_after", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e; obs_t o; in_t i;
    i = idle_in(); i.ex_valid = 1'b1; i.ex_pcsrc = 1'b1; i.pc_next = 16'h0040; i.mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(i, $sformatf("busy%0d", k), C_STALL, M_ALL, 1'b0, 16'h0, 1'b1, 1'b1);
    end
    i.mem_busy = 1'b0;
    apply(i, "busy_exit_br", C_BR, M_ALL, 1'b1, 16'h0040, 1'b1, 1'b0);
    apply(idle_in(), "busy_after", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e; obs_t o;
    int   t;
    ex_valid = 1'b0; ex_pcsrc = 1'b0; ex_halt = 1'b0; mem_busy = 1'b0; ex_pc_next = 16'h0;
    id_ex_memread = 1'b1; id_ex_rd = 3'd2; if_id_rs = 3'd2; if_id_rt = 3'd0;
    if_id_rs_used = 1'b1; if_id_rt_used = 1'b0;
    repeat (65536) @(posedge clk);
    #1;
    t = int'(model_cnt) + 65536;
    model_cnt = (t > 65535) ? 16'hFFFF : 16'(t);
    apply(lu_in(3'd2, 3'd2, 3'd0, 1'b1, 1'b0), "sat0", C_LU, M_LU, 1'b0, 16'h0, 1'b1, 1'b1);
    apply(lu_in(3'd2, 3'd2, 3'd0, 1'b1, 1'b0), "sat1", C_LU, M_LU, 1'b0, 16'h0, 1'b1, 1'b1);
    apply(idle_in(), "sat_after", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  task automatic test_halt();
    exp_t e; obs_t o; in_t h; in_t b; in_t x;
    h = idle_in(); h.ex_valid = 1'b1; h.ex_halt = 1'b1; h.ex_pcsrc = 1'b1; h.pc_next = 16'h1234;
    b = idle_in(); b.mem_busy = 1'b1;
    x = lu_in(3'd1, 3'd1, 3'd1, 1'b1, 1'b1); x.ex_valid = 1'b1; x.ex_pcsrc = 1'b1; x.mem_busy = 1'b1;
    // Plain drain: halted exactly DRAIN edges after the halt edge.
    apply(h,         "halt_in",   C_HIN,    M_HIN, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(), "drain1",    C_DRN,    M_LU,  1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(), "drain2",    C_DRN,    M_LU,  1'b0, 16'h0, 1'b1, 1'b0);
    apply(x,         "halted_x",  C_HALTED, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(), "halted_i",  C_HALTED, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b0; model_cnt = 16'h0000;
    apply(idle_in(), "rst_from_halt", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(idle_in(), "run_again", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    // Drain interrupted by two busy cycles: halted two cycles later.
    apply(h,         "hb_in",     C_HIN,    M_HIN, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(b,         "hb_busy1",  C_STALL,  M_EN,  1'b0, 16'h0, 1'b1, 1'b0);
    apply(b,         "hb_busy2",  C_STALL,  M_ALL, 1'b0, 16'h0, 1'b0, 1'b0);
    apply(idle_in(), "hb_drain1", C_DRN,    M_LU,  1'b0, 16'h0, 1'b0, 1'b0);
    apply(idle_in(), "hb_drain2", C_DRN,    M_LU,  1'b0, 16'h0, 1'b0, 1'b0);
    apply(idle_in(), "hb_halted", C_HALTED, M_ALL, 1'b0, 16'h0, 1'b0, 1'b0);
    // Reset in the middle of DRAIN and of MEM_WAIT.
    rst_n = 1'b0; model_cnt = 16'h0000;
    apply(idle_in(), "rst_a", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(h,         "rd_in",     C_HIN, M_HIN, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(idle_in(), "rd_drain",  C_DRN, M_LU,  1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    apply(idle_in(), "rst_mid_drain", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(idle_in(), "rd_run",    C_RUN,   M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    apply(b,         "rw_busy",   C_STALL, M_ALL, 1'b0, 16'h0, 1'b1, 1'b1);
    apply(b,         "rw_busy2",  C_STALL, M_ALL, 1'b0, 16'h0, 1'b1, 1'b1);
    rst_n = 1'b0; model_cnt = 16'h0000;
    apply(idle_in(), "rst_mid_wait", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(idle_in(), "rw_run", C_RUN, M_ALL, 1'b0, 16'h0, 1'b1, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = obs_q.pop_front();
      checks++;
      if ((o.ctl & e.msk) !== (e.ctl & e.msk)) begin
        errors++; $display("FAIL %s ctl got %b want %b mask %b", e.name, o.ctl, e.ctl, e.msk);
      end
      if (e.chk_tgt) begin
        checks++;
        if (o.tgt !== e.tgt) begin errors++; $display("FAIL %s pc_target got %h want %h", e.name, o.tgt, e.tgt); end
      end
      if (e.chk_cnt) begin
        checks++;
        if (o.cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.name, o.cnt, e.cnt); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_pcsrc = 1'b0; ex_halt = 1'b0; ex_pc_next = 16'h0;
    id_ex_memread = 1'b0; id_ex_rd = 3'd0; if_id_rs = 3'd0; if_id_rt = 3'd0;
    if_id_rs_used = 1'b0; if_id_rt_used = 1'b0; mem_busy = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_saturation();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 16-bit core.
- Generates PC and pipeline-register write enables and flushes from four sources:
  - EX-stage branch/jump resolution
  - load-use hazards detected in ID
  - data-memory busy
  - HALT instruction
- Drains the pipeline on HALT and then parks.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 16, PC/address width.
- REGW, 3, register specifier width.
- DRAIN, 2, cycles after HALT leaves EX before halted asserts (EX/MEM and MEM/WB retire).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_pcsrc  in  1  EX resolved taken branch or jump.
- ex_pc_next  in  WIDTH  redirect target computed in EX.
- ex_halt  in  1  EX instruction is HALT.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  REGW  destination of instruction in EX.
- if_id_rs, if_id_rt  in  REGW  source specifiers of instruction in ID.
- if_id_rs_used, if_id_rt_used  in  1  ID actually reads rs / rt.
- mem_busy  in  1  data memory not ready this cycle.
- pc_we  out  1  PC register write enable.
- pc_sel  out  1  1 = load pc_target, 0 = sequential PC.
- pc_target  out  WIDTH  equals ex_pc_next.
- if_id_we, id_ex_we, ex_mem_we  out  1  pipeline register enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (valid=0) into the register.
- halted  out  1  core stopped.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT. The state, the return flag ret_drain, the drain counter (ceil(log2(DRAIN+1)) bits) and stall_cnt are registered.
- Reset (async, rst_n=0):
  - state=RUN, stall_cnt=0, counter=0, ret_drain=0.
  - Outputs: enables=1, flushes=0, pc_sel=0, halted=0.
- Outputs are Mealy: combinational from state and current inputs, taking effect at the same rising edge.
- RUN priority, highest first:
  1. mem_busy: all enables=0, flushes=0; next=MEM_WAIT, ret_drain=0; stall_cnt++.
  2. ex_valid&ex_halt: pc_we=0, if_id_flush=1, id_ex_flush=1, ex_mem_we=1; next=DRAIN, counter=DRAIN-1. ex_pcsrc is ignored.
  3. ex_valid&ex_pcsrc: pc_we=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, all others we=1. Any load-use hazard is ignored because the dependent instruction is squashed.
  4. Load-use: id_ex_memread & ((if_id_rs_used & rs==rd) | (if_id_rt_used & rt==rd)), r0 included.
     - pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cnt++.
     - Lasts one cycle: the load advances, so the hazard clears.
  5. Otherwise all enables=1, flushes=0, pc_sel=0.
- MEM_WAIT:
  - While mem_busy: all enables=0, flushes=0; stall_cnt++. The EX instruction is frozen, so a pending redirect is re-evaluated on exit.
  - First cycle mem_busy=0: return to DRAIN if ret_drain=1, else RUN. Outputs that cycle are those of the target state.
- DRAIN:
  - pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1.
  - If counter==0, next=HALT; else decrement.
  - mem_busy: freeze the counter, all enables=0, next=MEM_WAIT with ret_drain=1.
- HALT:
  - All enables=0, flushes=0, halted=1.
  - Exited only by reset; all inputs ignored.
- stall_cnt:
  - Saturates at 16'hFFFF.
  - Never increments in DRAIN or HALT.
- pc_sel is 0 whenever pc_we=0.
- Reset mid-DRAIN or mid-MEM_WAIT returns immediately to reset values.

Test Plan:
- Reset, then idle with all inputs 0 -> pc_we=if_id_we=id_ex_we=ex_mem_we=1, flushes=0, halted=0, stall_cnt=0.
- id_ex_memread=1, id_ex_rd=3, if_id_rs=3, if_id_rs_used=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle only; stall_cnt=1. Repeat with if_id_rs_used=0 -> no stall.
- ex_valid=1, ex_pcsrc=1, ex_pc_next=16'h0040, plus a simultaneous load-use hazard -> pc_sel=1, pc_target=0x0040, if_id_flush=id_ex_flush=1, no stall, stall_cnt unchanged.
- mem_busy high 3 cycles with ex_pcsrc=1 held -> all enables 0 for 3 cycles, stall_cnt=3; redirect to 0x0040 issued on the 4th cycle.
- ex_halt with DRAIN=2 -> halted=1 exactly 2 cycles after the halt edge. Also: mem_busy for 2 cycles mid-drain -> halted delayed by 2 cycles; all enables 0 in HALT; rst_n low then high -> RUN.
- Force 65536 load-use stalls -> stall_cnt stays 16'hFFFF.
